// File: rtl/psk_pkg.sv
// Shared definitions for the PSK transmit bit path.
//  - pn_state_e : frame sequencer state encoding (IDLE=0, PREAMBLE=1, PAYLOAD=2, GAP=3)
//  - PN tap masks and the common seed for the supported LFSR orders (4 and 5)
//  - pn_period(n) : PN sequence period 2^n-1
//  - cnt_span(a,b,c) : largest of a, b, c and 2, used to size frame counters
package psk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } pn_state_e;

  // Tap masks select the state bits XORed into the new LSB.
  // Order 5: s[4]^s[2]; order 4: s[3]^s[2].
  localparam logic [4:0] PN5_TAPS = 5'b10100;
  localparam logic [4:0] PN4_TAPS = 5'b01100;
  localparam logic [4:0] PN_SEED  = 5'b00001;

  function automatic logic [4:0] pn_taps(input int n);
    case (n)
      32'sd4:  pn_taps = PN4_TAPS;
      default: pn_taps = PN5_TAPS;
    endcase
  endfunction

  function automatic int pn_period(input int n);
    return (32'sd1 <<< n) - 32'sd1;
  endfunction

  function automatic int cnt_span(input int a, input int b, input int c);
    int m;
    m = 32'sd2;
    m = (a > m) ? a : m;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    return m;
  endfunction

endpackage

// File: rtl/pn_lfsr.sv
// Fibonacci-style PN generator used for the frame preamble.
// Ports:
//  clk    in  system clock
//  rst    in  synchronous active-high reset, reloads the seed
//  load   in  reload the seed (wins over adv)
//  adv    in  step the register once
//  pn_bit out current output bit (MSB of the state)
// An all-zero state can never advance on its own, so it is forced back to
// the seed on the next edge whatever adv says.
module pn_lfsr
  import psk_pkg::*;
#(
  parameter int PN_N = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic adv,
  output logic pn_bit
);

  localparam logic [4:0]      TAPS_FULL = pn_taps(PN_N);
  localparam logic [PN_N-1:0] TAPS      = TAPS_FULL[PN_N-1:0];
  localparam logic [PN_N-1:0] SEED      = PN_SEED[PN_N-1:0];
  localparam logic [PN_N-1:0] ZERO      = {PN_N{1'b0}};

  logic [PN_N-1:0] lfsr_r;
  logic [PN_N-1:0] lfsr_next_s;
  logic            feedback_s;

  // Next state: shift left, XOR of the tapped bits enters at bit 0.
  always_comb begin
    feedback_s  = ^(lfsr_r & TAPS);
    lfsr_next_s = {lfsr_r[PN_N-2:0], feedback_s};
  end

  // State register: seed on reset/load, lock-up recovery, then stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= SEED;
    end else if (lfsr_r == ZERO) begin
      lfsr_r <= SEED;
    end else if (adv) begin
      lfsr_r <= lfsr_next_s;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign pn_bit = lfsr_r[PN_N-1];

endmodule

// File: rtl/pn_frame_ctrl.sv
// Frame sequencer for the PSK transmit bit path: PN preamble, payload from
// an upstream source, then an idle gap. All bit advances happen on sym_en.
// Ports:
//  clk, rst      clock and synchronous active-high reset
//  sym_en        symbol strobe
//  start         frame request (honoured only in IDLE)
//  data_in       payload bit from upstream
//  data_valid    upstream bit available
//  data_ready    combinational, payload slot taken this cycle
//  bit_out       registered output bit
//  bit_valid     registered one-cycle pulse per emitted bit
//  is_pre        registered, marks preamble bits
//  busy          high whenever not IDLE
//  frame_done    one-cycle pulse at the end of a frame
//  underrun      one-cycle pulse for a payload slot without valid data
module pn_frame_ctrl
  import psk_pkg::*;
#(
  parameter int PN_N        = 5,
  parameter int PRE_REPS    = 2,
  parameter int PAYLOAD_LEN = 64,
  parameter int GAP_LEN     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sym_en,
  input  logic start,
  input  logic data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic bit_out,
  output logic bit_valid,
  output logic is_pre,
  output logic busy,
  output logic frame_done,
  output logic underrun
);

  localparam int PRE_LEN = PRE_REPS * pn_period(PN_N);
  localparam int CNT_W   = $clog2(cnt_span(PRE_LEN, PAYLOAD_LEN, GAP_LEN));
  localparam bit HAS_GAP = (GAP_LEN > 0);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 32'sd1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 32'sd1);
  localparam logic [CNT_W-1:0] GAP_LAST = HAS_GAP ? CNT_W'(GAP_LEN - 32'sd1) : CNT_ZERO;

  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_PREAMBLE = ST_PREAMBLE;
  localparam logic [1:0] S_PAYLOAD  = ST_PAYLOAD;
  localparam logic [1:0] S_GAP      = ST_GAP;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             bit_out_r;
  logic             bit_valid_r;
  logic             is_pre_r;
  logic             frame_done_r;
  logic             underrun_r;
  logic             lfsr_load_s;
  logic             lfsr_adv_s;
  logic             pn_bit_s;

  // LFSR control: reseed when a frame is accepted, step once per preamble symbol.
  always_comb begin
    lfsr_load_s = 1'b0;
    lfsr_adv_s  = 1'b0;
    if (state_r == S_IDLE) begin
      lfsr_load_s = start;
    end else begin
      lfsr_load_s = 1'b0;
    end
    if (state_r == S_PREAMBLE) begin
      lfsr_adv_s = sym_en;
    end else begin
      lfsr_adv_s = 1'b0;
    end
  end

  pn_lfsr #(
    .PN_N (PN_N)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load_s),
    .adv    (lfsr_adv_s),
    .pn_bit (pn_bit_s)
  );

  // Frame state, symbol counter and registered outputs. Pulse outputs
  // default low and are raised only in the cycle after their event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= CNT_ZERO;
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      is_pre_r     <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      is_pre_r     <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          cnt_r <= CNT_ZERO;
          if (start) begin
            state_r <= S_PREAMBLE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_PREAMBLE: begin
          if (sym_en) begin
            bit_out_r   <= pn_bit_s;
            bit_valid_r <= 1'b1;
            is_pre_r    <= 1'b1;
            if (cnt_r == PRE_LAST) begin
              state_r <= S_PAYLOAD;
              cnt_r   <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        S_PAYLOAD: begin
          if (sym_en) begin
            bit_valid_r <= 1'b1;
            // A missing bit still uses up its slot so frame length is fixed.
            if (data_valid) begin
              bit_out_r <= data_in;
            end else begin
              bit_out_r  <= 1'b0;
              underrun_r <= 1'b1;
            end
            if (cnt_r == PAY_LAST) begin
              cnt_r <= CNT_ZERO;
              if (HAS_GAP) begin
                state_r <= S_GAP;
              end else begin
                state_r      <= S_IDLE;
                frame_done_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        S_GAP: begin
          if (sym_en) begin
            if (cnt_r == GAP_LAST) begin
              state_r      <= S_IDLE;
              cnt_r        <= CNT_ZERO;
              frame_done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign data_ready = (state_r == S_PAYLOAD) && sym_en;
  assign busy       = (state_r != S_IDLE);
  assign bit_out    = bit_out_r;
  assign bit_valid  = bit_valid_r;
  assign is_pre     = is_pre_r;
  assign frame_done = frame_done_r;
  assign underrun   = underrun_r;

endmodule
